beep_sequencer: RTL and testbench

Sequencer and arbiter in front of the beep voice. It accepts one-cycle trigger pulses from up to `NUM_REQ` game-logic requesters and grants the single beep voice to one of them, using fixed priority. It drives the voice's `beep_en` for a per-requester duration counted in audio samples, then inserts a silent gap so the RC envelope filter can decay before the next grant. It sits between the game-event logic and the beep voice, in the same `clk` / `audio_clk_en` domain.

---
 rtl/beep_seq_pkg.sv | 21 ++
 rtl/beep_seq_prio_enc.sv | 34 +++
 rtl/beep_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_beep_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beep_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : beep_seq_pkg                                           |
// | Description : Shared types and defaults for the beep sequencer:      |
// |               sequencer state encoding and default gap length.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package beep_seq_pkg;

    // Sequencer states; explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } beep_seq_state_t;

    // 10 ms of silence at 48 kHz lets the RC envelope decay between beeps.
    localparam int DEFAULT_GAP_SAMPLES = 480;

endpackage : beep_seq_pkg
`default_nettype wire

// File: rtl/beep_seq_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : beep_seq_prio_enc                                      |
// | Description : Combinational fixed-priority encoder, lowest index     |
// |               wins. Produces a valid flag, the winning index and a   |
// |               one-hot copy of the winner.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module beep_seq_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid  = |vec;
        idx    = '0;
        onehot = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx       = IDX_W'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule : beep_seq_prio_enc
`default_nettype wire

// File: rtl/beep_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : beep_sequencer                                         |
// | Description : Fixed-priority arbiter and sequencer for the single    |
// |               beep voice. Grants one requester at a time, gates      |
// |               beep_en for that requester's duration in audio         |
// |               samples, then holds a silent gap before the next       |
// |               grant. Lower index preempts, same index retriggers.    |
// |               Build option BEEP_SEQ_QUEUE_EN: keep one pending bit   |
// |               per requester instead of dropping losing requests.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module beep_sequencer
    import beep_seq_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DUR_W       = 16,
    parameter int GAP_SAMPLES = DEFAULT_GAP_SAMPLES
) (
    input  logic                       clk,
    input  logic                       I_RST,
    input  logic                       audio_clk_en,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DUR_W-1:0]   req_dur,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         dropped,
    output logic                       beep_en,
    output logic [$clog2(NUM_REQ)-1:0] active_id,
    output logic                       busy,
    output logic                       done
);

    localparam int               c_id_w     = $clog2(NUM_REQ);
    localparam logic             c_gap_en   = (GAP_SAMPLES != 0);
    localparam logic [DUR_W-1:0] c_gap_load = DUR_W'(GAP_SAMPLES);
    localparam logic [DUR_W-1:0] c_cnt_one  = DUR_W'(1);

    beep_seq_state_t     r_state;
    beep_seq_state_t     w_state_next;
    beep_seq_state_t     w_exit_state;
    logic [DUR_W-1:0]    r_cnt;
    logic [DUR_W-1:0]    w_cnt_next;
    logic [DUR_W-1:0]    w_exit_cnt;
    logic [c_id_w-1:0]   r_active_id;
    logic [c_id_w-1:0]   w_active_next;
    logic [NUM_REQ-1:0]  r_pend;
    logic [NUM_REQ-1:0]  w_pend_next;
    logic [NUM_REQ-1:0]  r_ack;
    logic [NUM_REQ-1:0]  w_ack_next;
    logic [NUM_REQ-1:0]  r_drop;
    logic [NUM_REQ-1:0]  w_drop_next;
    logic                r_beep;
    logic                w_beep_next;
    logic                r_busy;
    logic                w_busy_next;
    logic                r_done;
    logic                w_done_next;
    logic                w_grant;
    logic                w_done_evt;

    logic [NUM_REQ-1:0]  w_cand;
    logic                w_win_valid;
    logic [c_id_w-1:0]   w_win_idx;
    logic [NUM_REQ-1:0]  w_win_oh;
    logic [DUR_W-1:0]    w_win_dur;

    // Fresh triggers and anything still waiting compete together.
    assign w_cand    = req | r_pend;
    assign w_win_dur = req_dur[w_win_idx*DUR_W +: DUR_W];

    // A completed beep goes through the gap unless the gap is disabled.
    assign w_exit_state = c_gap_en ? GAP : IDLE;
    assign w_exit_cnt   = c_gap_en ? c_gap_load : '0;

    beep_seq_prio_enc #(
        .N     (NUM_REQ),
        .IDX_W (c_id_w)
    ) u_prio_enc (
        .vec    (w_cand),
        .valid  (w_win_valid),
        .idx    (w_win_idx),
        .onehot (w_win_oh)
    );

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (I_RST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_active_id <= '0;
            r_pend      <= '0;
            r_ack       <= '0;
            r_drop      <= '0;
            r_beep      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_active_id <= w_active_next;
            r_pend      <= w_pend_next;
            r_ack       <= w_ack_next;
            r_drop      <= w_drop_next;
            r_beep      <= w_beep_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
        end
    end

    // Next state: grants, preemption/retrigger, countdown and completion.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_active_next = r_active_id;
        w_grant       = 1'b0;
        w_done_evt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_win_valid) begin
                    w_grant = 1'b1;
                    if (w_win_dur == '0) begin
                        // Zero-length beep completes on the spot.
                        w_done_evt = 1'b1;
                    end else begin
                        w_state_next  = PLAY;
                        w_cnt_next    = w_win_dur;
                        w_active_next = w_win_idx;
                    end
                end
            end
            PLAY: begin
                // Equal index retriggers, lower index preempts; both beat
                // a completion landing in the same cycle.
                if (w_win_valid && (w_win_idx <= r_active_id)) begin
                    w_grant       = 1'b1;
                    w_active_next = w_win_idx;
                    if (w_win_dur == '0) begin
                        w_done_evt   = 1'b1;
                        w_state_next = w_exit_state;
                        w_cnt_next   = w_exit_cnt;
                        if (!c_gap_en) begin
                            w_active_next = '0;
                        end
                    end else begin
                        w_cnt_next = w_win_dur;
                    end
                end else if (audio_clk_en) begin
                    if (r_cnt <= c_cnt_one) begin
                        w_done_evt   = 1'b1;
                        w_state_next = w_exit_state;
                        w_cnt_next   = w_exit_cnt;
                        if (!c_gap_en) begin
                            w_active_next = '0;
                        end
                    end else begin
                        w_cnt_next = r_cnt - c_cnt_one;
                    end
                end
            end
            GAP: begin
                // The gap is never cut short; requests here wait or drop.
                if (audio_clk_en) begin
                    if (r_cnt <= c_cnt_one) begin
                        w_state_next  = IDLE;
                        w_cnt_next    = '0;
                        w_active_next = '0;
                    end else begin
                        w_cnt_next = r_cnt - c_cnt_one;
                    end
                end
            end
            default: begin
                w_state_next  = IDLE;
                w_cnt_next    = '0;
                w_active_next = '0;
            end
        endcase
    end

    // Registered-output next values and pending/drop bookkeeping.
    always_comb begin
        w_ack_next  = w_grant ? w_win_oh : '0;
        w_done_next = w_done_evt;
        w_beep_next = (w_state_next == PLAY);
        w_busy_next = (w_state_next != IDLE);
`ifdef BEEP_SEQ_QUEUE_EN
        w_pend_next = (r_pend | req) & ~w_ack_next;
        w_drop_next = '0;
`else
        w_pend_next = '0;
        w_drop_next = req & ~w_ack_next;
`endif
    end

    assign ack       = r_ack;
    assign dropped   = r_drop;
    assign beep_en   = r_beep;
    assign active_id = r_active_id;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule : beep_sequencer
`default_nettype wire

// File: tb/tb_beep_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_beep_sequencer                                      |
// | Description : Self-checking bench for beep_sequencer: directed       |
// |               scenarios with literal expectations, then random       |
// |               traffic compared every cycle against a behavioural     |
// |               model of voice ownership, remaining time and gap.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_beep_sequencer;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int GS = 3;

    logic             clk = 1'b0;
    logic             I_RST;
    logic             audio_clk_en;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] req_dur;
    logic [NR-1:0]    ack;
    logic [NR-1:0]    dropped;
    logic             beep_en;
    logic [1:0]       active_id;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;
    int dur [NR];
    int div_ph = 0;
    int done_seen = 0;

    // Model: voice mode 0 free / 1 playing / 2 silent gap.
    int            m_mode  = 0;
    int            m_owner = 0;
    int            m_rem   = 0;
    int            m_gap   = 0;
    logic [NR-1:0] m_pend  = '0;
    logic [NR-1:0] e_ack   = '0;
    logic [NR-1:0] e_drop  = '0;
    logic          e_done  = 1'b0;

    beep_sequencer #(
        .NUM_REQ     (NR),
        .DUR_W       (DW),
        .GAP_SAMPLES (GS)
    ) dut (
        .clk          (clk),
        .I_RST        (I_RST),
        .audio_clk_en (audio_clk_en),
        .req          (req),
        .req_dur      (req_dur),
        .ack          (ack),
        .dropped      (dropped),
        .beep_en      (beep_en),
        .active_id    (active_id),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    task automatic set_dur(input int i, input int v);
        dur[i] = v;
        req_dur[i*DW +: DW] = DW'(v);
    endtask

    task automatic m_finish();
        e_done = 1'b1;
        if (GS > 0) begin
            m_mode = 2;
            m_gap  = GS;
        end else begin
            m_mode = 0;
        end
    endtask

    task automatic m_grant(input int w);
        e_ack[w] = 1'b1;
        m_owner  = w;
        if (dur[w] == 0) begin
            if (m_mode == 1) m_finish();
            else e_done = 1'b1;
        end else begin
            m_mode = 1;
            m_rem  = dur[w];
        end
    endtask

    task automatic model_step();
        logic [NR-1:0] cand;
        int win;
        e_ack  = '0;
        e_drop = '0;
        e_done = 1'b0;
        if (I_RST) begin
            m_mode = 0; m_owner = 0; m_rem = 0; m_gap = 0; m_pend = '0;
            return;
        end
        cand = req | m_pend;
        win  = -1;
        for (int i = NR - 1; i >= 0; i--) if (cand[i]) win = i;
        case (m_mode)
            0: if (win >= 0) m_grant(win);
            1: begin
                if (win >= 0 && win <= m_owner) m_grant(win);
                else if (audio_clk_en) begin
                    m_rem--;
                    if (m_rem == 0) m_finish();
                end
            end
            default: begin
                if (audio_clk_en) begin
                    m_gap--;
                    if (m_gap == 0) m_mode = 0;
                end
            end
        endcase
`ifdef BEEP_SEQ_QUEUE_EN
        m_pend = (m_pend | req) & ~e_ack;
`else
        e_drop = req & ~e_ack;
`endif
    endtask

    // One clock: model consumes the sampled inputs, DUT checked 2 ns later.
    task automatic do_cycle();
        @(posedge clk);
        model_step();
        #2;
        chk("ack", ack, e_ack);
        chk("dropped", dropped, e_drop);
        chk("done", done, e_done);
        chk("beep_en", beep_en, (m_mode == 1) ? 1 : 0);
        chk("busy", busy, (m_mode != 0) ? 1 : 0);
        chk("active_id", active_id, (m_mode != 0) ? m_owner : 0);
        if (done) done_seen++;
    endtask

    task automatic tick_div();
        audio_clk_en = (div_ph == 3);
        div_ph = (div_ph + 1) % 4;
    endtask

    task automatic pulse(input logic [NR-1:0] r, input logic te);
        req = r;
        audio_clk_en = te;
        do_cycle();
        req = '0;
        audio_clk_en = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        int t = 0;
        int guard = 0;
        while (t < n && guard < 1000) begin
            tick_div();
            do_cycle();
            if (audio_clk_en) t++;
            guard++;
        end
        if (t < n) fail_timeout("run_ticks");
    endtask

    // Counts ticks until done (want_done) or until busy drops.
    task automatic ticks_until(input bit want_done, output int ticks);
        int guard = 0;
        bit hit = 1'b0;
        ticks = 0;
        while (!hit && guard < 2000) begin
            tick_div();
            do_cycle();
            if (audio_clk_en) ticks++;
            hit = want_done ? done : !busy;
            guard++;
        end
        audio_clk_en = 1'b0;
        if (!hit) fail_timeout(want_done ? "wait_done" : "wait_idle");
    endtask

    task automatic single_test(input string tag);
        int t;
        set_dur(2, 5);
        pulse(4'b0100, 1'b0);
        chk({tag, "_ack"}, ack, 4);
        chk({tag, "_id"}, active_id, 2);
        chk({tag, "_beep_on"}, beep_en, 1);
        ticks_until(1'b1, t);
        chk({tag, "_play_ticks"}, t, 5);
        chk({tag, "_beep_off"}, beep_en, 0);
        ticks_until(1'b0, t);
        chk({tag, "_gap_ticks"}, t, 3);
    endtask

    initial begin
        int t;
        I_RST = 1'b1;
        req = '0;
        audio_clk_en = 1'b0;
        req_dur = '0;
        for (int i = 0; i < NR; i++) set_dur(i, 0);
        do_cycle();
        do_cycle();
        chk("rst_beep", beep_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        I_RST = 1'b0;
        do_cycle();

        // Single request.
        single_test("single");

        // Preemption by a higher-priority requester.
        done_seen = 0;
        set_dur(3, 100);
        pulse(4'b1000, 1'b0);
        run_ticks(10);
        set_dur(0, 4);
        pulse(4'b0001, 1'b0);
        chk("preempt_ack", ack, 1);
        chk("preempt_id", active_id, 0);
        chk("preempt_beep", beep_en, 1);
        ticks_until(1'b1, t);
        chk("preempt_ticks", t, 4);
        chk("preempt_done_cnt", done_seen, 1);
        ticks_until(1'b0, t);

        // Retrigger by the current owner at its 7th tick.
        done_seen = 0;
        set_dur(1, 10);
        pulse(4'b0010, 1'b0);
        run_ticks(6);
        pulse(4'b0010, 1'b1);
        chk("retrig_ack", ack, 2);
        ticks_until(1'b1, t);
        chk("retrig_total", 7 + t, 17);
        chk("retrig_done_cnt", done_seen, 1);
        ticks_until(1'b0, t);

        // Simultaneous requests on lines 1 and 2.
        set_dur(1, 3);
        set_dur(2, 3);
        pulse(4'b0110, 1'b0);
        chk("simul_ack", ack, 2);
`ifdef BEEP_SEQ_QUEUE_EN
        chk("simul_nodrop", dropped, 0);
        ticks_until(1'b1, t);
        ticks_until(1'b0, t);
        pulse(4'b0000, 1'b0);
        chk("simul_q_ack2", ack, 4);
        chk("simul_q_id2", active_id, 2);
`else
        chk("simul_drop", dropped, 4);
`endif
        ticks_until(1'b0, t);

        // Zero duration.
        set_dur(0, 0);
        pulse(4'b0001, 1'b0);
        chk("zero_ack", ack, 1);
        chk("zero_done", done, 1);
        chk("zero_beep", beep_en, 0);
        chk("zero_busy", busy, 0);
        pulse(4'b0000, 1'b0);
        chk("zero_beep_after", beep_en, 0);

        // Reset in the middle of a beep.
        set_dur(2, 8);
        pulse(4'b0100, 1'b0);
        run_ticks(3);
        I_RST = 1'b1;
        do_cycle();
        chk("midrst_beep", beep_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_drop", dropped, 0);
        chk("midrst_ack", ack, 0);
        chk("midrst_id", active_id, 0);
        I_RST = 1'b0;
        do_cycle();
        single_test("after_rst");

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            I_RST = ($urandom_range(0, 499) == 0);
            audio_clk_en = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < NR; i++) begin
                req[i] = ($urandom_range(0, 11) == 0);
                if ($urandom_range(0, 7) == 0) set_dur(i, int'($urandom_range(0, 10)));
            end
            do_cycle();
        end
        I_RST = 1'b0;
        req = '0;
        audio_clk_en = 1'b0;
        do_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_beep_sequencer
`default_nettype wire
